// File: rtl/mem_rr_port_arbiter_if.sv
// mem_rr_port_arbiter_if
//   Bundles the request, response and memory-side signals of the memory
//   port arbiter into one interface.
//   Ports (all carried in the interface):
//     ld_addr_valid/ld_addr_ready/ld_addr  : load address requests
//     ld_data_valid/ld_data_ready/ld_data  : load responses
//     st_addr_valid/st_data_valid/st_ready : joined store handshake
//     st_addr/st_data                      : store address and data
//     mem_en/mem_we/mem_addr/mem_wdata     : single-port memory command
//     mem_rdata                            : memory read data (1-cycle latency)
//     idle                                 : nothing requested, in flight or held
//   slave  : arbiter side
//   master : requesters plus memory side
interface mem_rr_port_arbiter_if #(
  parameter int LOAD_COUNT  = 2,
  parameter int STORE_COUNT = 1,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
);
  logic [LOAD_COUNT-1:0]             ld_addr_valid;
  logic [LOAD_COUNT-1:0]             ld_addr_ready;
  logic [LOAD_COUNT*ADDR_WIDTH-1:0]  ld_addr;
  logic [LOAD_COUNT-1:0]             ld_data_valid;
  logic [LOAD_COUNT-1:0]             ld_data_ready;
  logic [LOAD_COUNT*DATA_WIDTH-1:0]  ld_data;
  logic [STORE_COUNT-1:0]            st_addr_valid;
  logic [STORE_COUNT-1:0]            st_data_valid;
  logic [STORE_COUNT-1:0]            st_ready;
  logic [STORE_COUNT*ADDR_WIDTH-1:0] st_addr;
  logic [STORE_COUNT*DATA_WIDTH-1:0] st_data;
  logic                              mem_en;
  logic                              mem_we;
  logic [ADDR_WIDTH-1:0]             mem_addr;
  logic [DATA_WIDTH-1:0]             mem_wdata;
  logic [DATA_WIDTH-1:0]             mem_rdata;
  logic                              idle;

  modport slave (
    input  ld_addr_valid, ld_addr, ld_data_ready,
    input  st_addr_valid, st_data_valid, st_addr, st_data,
    input  mem_rdata,
    output ld_addr_ready, ld_data_valid, ld_data, st_ready,
    output mem_en, mem_we, mem_addr, mem_wdata, idle
  );

  modport master (
    output ld_addr_valid, ld_addr, ld_data_ready,
    output st_addr_valid, st_data_valid, st_addr, st_data,
    output mem_rdata,
    input  ld_addr_ready, ld_data_valid, ld_data, st_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata, idle
  );
endinterface

// File: rtl/mem_rr_port_arbiter.sv
// mem_rr_port_arbiter
//   Round-robin arbiter sharing one single-port synchronous memory between
//   LOAD_COUNT load ports and STORE_COUNT store ports. At most one access is
//   granted per cycle; load data returns two cycles after the grant through a
//   per-port holding register with a valid/ready handshake.
//   Ports:
//     clk : clock, rising edge
//     rst : asynchronous reset, active-high
//     bus : mem_rr_port_arbiter_if.slave (requests, responses, memory side)
//   Configuration macro:
//     MEM_ARB_STORE_FIRST_EN : when defined, eligible stores are always
//       scanned before loads; loads only win in cycles with no eligible store.
module mem_rr_port_arbiter #(
  parameter int LOAD_COUNT  = 2,
  parameter int STORE_COUNT = 1,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  mem_rr_port_arbiter_if.slave     bus
);
  // Requester index: loads first, then stores.
  localparam int T     = LOAD_COUNT + STORE_COUNT;
  localparam int PTR_W = (T > 1) ? $clog2(T) : 1;

  logic [T-1:0]          elig;
  logic [T-1:0]          scan_mask;
  logic [T-1:0]          grant;
  logic [PTR_W-1:0]      ptr_reg;
  logic [PTR_W-1:0]      ptr_next;
  logic [LOAD_COUNT-1:0] inflight_vec;
  logic [LOAD_COUNT-1:0] resp_valid_vec;

  // Per-load response path.
  for (genvar gi = 0; gi < LOAD_COUNT; gi++) begin : g_load
    logic                  inflight_reg;
    logic                  resp_valid_reg;
    logic [DATA_WIDTH-1:0] resp_data_reg;

    // A port may be re-granted while its held response drains in the same
    // cycle, so the new capture can never land on undrained data.
    assign elig[gi] = bus.ld_addr_valid[gi] & ~inflight_reg &
                      (~resp_valid_reg | bus.ld_data_ready[gi]);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        inflight_reg   <= 1'b0;
        resp_valid_reg <= 1'b0;
        resp_data_reg  <= '0;
      end else begin
        // A port is never granted while in flight, so the flag simply
        // follows the grant by one cycle.
        inflight_reg <= grant[gi];
        if (inflight_reg) begin
          // Capture wins over a same-edge drain.
          resp_valid_reg <= 1'b1;
          resp_data_reg  <= bus.mem_rdata;
        end else if (resp_valid_reg && bus.ld_data_ready[gi]) begin
          resp_valid_reg <= 1'b0;
        end
      end
    end

    assign inflight_vec[gi]                            = inflight_reg;
    assign resp_valid_vec[gi]                          = resp_valid_reg;
    assign bus.ld_data_valid[gi]                       = resp_valid_reg;
    assign bus.ld_data[gi*DATA_WIDTH +: DATA_WIDTH]    = resp_data_reg;
  end

  // Stores need address and data together; neither is accepted alone.
  for (genvar gi = 0; gi < STORE_COUNT; gi++) begin : g_store
    assign elig[LOAD_COUNT+gi] = bus.st_addr_valid[gi] & bus.st_data_valid[gi];
  end

`ifdef MEM_ARB_STORE_FIRST_EN
  logic any_store_elig;
  assign any_store_elig = |elig[T-1:LOAD_COUNT];
  assign scan_mask = any_store_elig ? {elig[T-1:LOAD_COUNT], {LOAD_COUNT{1'b0}}} : elig;
`else
  assign scan_mask = elig;
`endif

  // First candidate scanning ptr, ptr+1, ... with wrap modulo T.
  always_comb begin
    int               idx;
    logic             found;
    logic [PTR_W-1:0] idx_sel;
    grant    = '0;
    ptr_next = ptr_reg;
    found    = 1'b0;
    idx      = 0;
    idx_sel  = '0;
    for (int k = 0; k < T; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= T) idx = idx - T;
      idx_sel = PTR_W'(idx);
      if (!found && scan_mask[idx_sel]) begin
        found          = 1'b1;
        grant[idx_sel] = 1'b1;
        ptr_next       = (idx == T - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_reg <= '0;
    else     ptr_reg <= ptr_next;
  end

  // Grant is one-hot or zero, so OR-ing the masked sources is a mux.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    for (int i = 0; i < LOAD_COUNT; i++) begin
      if (grant[i]) bus.mem_addr = bus.mem_addr | bus.ld_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
    for (int j = 0; j < STORE_COUNT; j++) begin
      if (grant[LOAD_COUNT+j]) begin
        bus.mem_addr  = bus.mem_addr  | bus.st_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        bus.mem_wdata = bus.mem_wdata | bus.st_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.ld_addr_ready = grant[LOAD_COUNT-1:0];
  assign bus.st_ready      = grant[T-1:LOAD_COUNT];
  assign bus.mem_en        = |grant;
  assign bus.mem_we        = |grant[T-1:LOAD_COUNT];
  assign bus.idle          = ~|bus.ld_addr_valid & ~|(bus.st_addr_valid | bus.st_data_valid) &
                             ~|inflight_vec & ~|resp_valid_vec;
endmodule

// File: tb/tb_mem_rr_port_arbiter.sv
module tb_mem_rr_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] tbmem [0:255];
  logic [31:0] rdata_q;

  mem_rr_port_arbiter_if #(.LOAD_COUNT(2), .STORE_COUNT(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_rr_port_arbiter #(.LOAD_COUNT(2), .STORE_COUNT(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory, 1-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) tbmem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else            rdata_q <= tbmem[bus.mem_addr[7:0]];
    end
  end
  assign bus.mem_rdata = rdata_q;

  task automatic clear_inputs();
    bus.ld_addr_valid = '0;
    bus.ld_addr       = '0;
    bus.ld_data_ready = '0;
    bus.st_addr_valid = '0;
    bus.st_data_valid = '0;
    bus.st_addr       = '0;
    bus.st_data       = '0;
  endtask

  // Leaves time at posedge+1 of the first cycle after reset.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    total++; if (bus.ld_data_valid !== 2'b00) begin bad++; $display("FAIL reset_ld_data_valid got=%b exp=00", bus.ld_data_valid); end
    total++; if (bus.ld_data !== 64'h0) begin bad++; $display("FAIL reset_ld_data got=%h exp=0", bus.ld_data); end
    total++; if (bus.idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", bus.idle); end
    total++; if ({bus.mem_en, bus.mem_we, bus.st_ready, bus.ld_addr_ready} !== 5'b0) begin bad++; $display("FAIL reset_grants got=%b exp=00000", {bus.mem_en, bus.mem_we, bus.st_ready, bus.ld_addr_ready}); end
    $display("test_reset: outputs after reset checked");
  endtask

  task automatic test_single_load();
    do_reset();
    bus.ld_addr_valid = 2'b01;
    bus.ld_addr       = {32'h0, 32'h10};
    bus.ld_data_ready = 2'b11;
    #2;
    total++; if (bus.ld_addr_ready !== 2'b01) begin bad++; $display("FAIL load_grant got=%b exp=01", bus.ld_addr_ready); end
    total++; if ({bus.mem_en, bus.mem_we} !== 2'b10) begin bad++; $display("FAIL load_en_we got=%b exp=10", {bus.mem_en, bus.mem_we}); end
    total++; if (bus.mem_addr !== 32'h10) begin bad++; $display("FAIL load_addr got=%h exp=10", bus.mem_addr); end
    step();
    bus.ld_addr_valid = 2'b00;
    #2;
    total++; if (bus.ld_data_valid !== 2'b00) begin bad++; $display("FAIL load_t1_valid got=%b exp=00", bus.ld_data_valid); end
    total++; if (bus.idle !== 1'b0) begin bad++; $display("FAIL load_t1_idle got=%b exp=0", bus.idle); end
    step();
    #2;
    total++; if (bus.ld_data_valid !== 2'b01) begin bad++; $display("FAIL load_t2_valid got=%b exp=01", bus.ld_data_valid); end
    total++; if (bus.ld_data[31:0] !== 32'hAB) begin bad++; $display("FAIL load_t2_data got=%h exp=ab", bus.ld_data[31:0]); end
    step();
    #2;
    total++; if (bus.ld_data_valid !== 2'b00) begin bad++; $display("FAIL load_drained got=%b exp=00", bus.ld_data_valid); end
    total++; if (bus.idle !== 1'b1) begin bad++; $display("FAIL load_idle got=%b exp=1", bus.idle); end
    $display("test_single_load: addr=0x10 data=0xab");
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [0:2];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
    do_reset();
    bus.ld_addr_valid = 2'b11;
    bus.ld_addr       = {32'h24, 32'h20};
    bus.ld_data_ready = 2'b11;
    bus.st_addr_valid = 1'b1;
    bus.st_data_valid = 1'b1;
    bus.st_addr       = 32'h30;
    bus.st_data       = 32'h99;
    for (int c = 0; c < 9; c++) begin
      #2;
      total++;
      if ({bus.st_ready, bus.ld_addr_ready} !== exp_g[c % 3]) begin
        bad++; $display("FAIL rr_grant cycle=%0d got=%b exp=%b", c, {bus.st_ready, bus.ld_addr_ready}, exp_g[c % 3]);
      end
      total++;
      if (bus.mem_we !== (c % 3 == 2)) begin
        bad++; $display("FAIL rr_we cycle=%0d got=%b exp=%b", c, bus.mem_we, (c % 3 == 2));
      end
      if (c == 2) begin
        total++;
        if (bus.ld_data_valid[0] !== 1'b1 || bus.ld_data[31:0] !== 32'h1111_0020) begin
          bad++; $display("FAIL rr_ld0_data got=%b/%h exp=1/11110020", bus.ld_data_valid[0], bus.ld_data[31:0]);
        end
      end
      $display("test_round_robin: cycle=%0d grant=%b", c, {bus.st_ready, bus.ld_addr_ready});
      step();
    end
    clear_inputs();
  endtask

  task automatic test_store_join();
    do_reset();
    bus.st_addr       = 32'h4;
    bus.st_data       = 32'h55;
    bus.st_addr_valid = 1'b1;
    #2;
    total++; if ({bus.st_ready, bus.mem_en} !== 2'b00) begin bad++; $display("FAIL store_addr_only got=%b exp=00", {bus.st_ready, bus.mem_en}); end
    total++; if (bus.idle !== 1'b0) begin bad++; $display("FAIL store_idle got=%b exp=0", bus.idle); end
    step();
    bus.st_data_valid = 1'b1;
    #2;
    total++; if ({bus.st_ready, bus.mem_en, bus.mem_we} !== 3'b111) begin bad++; $display("FAIL store_grant got=%b exp=111", {bus.st_ready, bus.mem_en, bus.mem_we}); end
    total++; if (bus.mem_addr !== 32'h4 || bus.mem_wdata !== 32'h55) begin bad++; $display("FAIL store_bus got=%h/%h exp=4/55", bus.mem_addr, bus.mem_wdata); end
    step();
    clear_inputs();
    #2;
    total++; if (tbmem[4] !== 32'h55) begin bad++; $display("FAIL store_written got=%h exp=55", tbmem[4]); end
    $display("test_store_join: addr=0x4 data=0x55");
  endtask

  task automatic test_hold();
    do_reset();
    bus.ld_addr       = {32'h40, 32'h0};
    bus.ld_addr_valid = 2'b10;
    bus.ld_data_ready = 2'b00;
    #2;
    total++; if (bus.ld_addr_ready !== 2'b10 || bus.mem_addr !== 32'h40) begin bad++; $display("FAIL hold_first_grant got=%b/%h exp=10/40", bus.ld_addr_ready, bus.mem_addr); end
    step();
    #2;
    total++; if (bus.ld_addr_ready !== 2'b00) begin bad++; $display("FAIL hold_inflight_grant got=%b exp=00", bus.ld_addr_ready); end
    step();
    for (int c = 0; c < 5; c++) begin
      #2;
      total++;
      if (bus.ld_data_valid !== 2'b10 || bus.ld_data[63:32] !== 32'hDEAD_0040 || bus.ld_addr_ready !== 2'b00) begin
        bad++; $display("FAIL hold_stable cycle=%0d got=%b/%h/%b exp=10/dead0040/00", c, bus.ld_data_valid, bus.ld_data[63:32], bus.ld_addr_ready);
      end
      step();
    end
    bus.ld_data_ready = 2'b10;
    #2;
    total++; if (bus.ld_addr_ready !== 2'b10) begin bad++; $display("FAIL hold_regrant got=%b exp=10", bus.ld_addr_ready); end
    step();
    bus.ld_addr_valid = 2'b00;
    #2;
    total++; if (bus.ld_data_valid !== 2'b00) begin bad++; $display("FAIL hold_drained got=%b exp=00", bus.ld_data_valid); end
    step();
    #2;
    total++; if (bus.ld_data_valid !== 2'b10 || bus.ld_data[63:32] !== 32'hDEAD_0040) begin bad++; $display("FAIL hold_second got=%b/%h exp=10/dead0040", bus.ld_data_valid, bus.ld_data[63:32]); end
    step();
    clear_inputs();
    $display("test_hold: port1 held 5 cycles then drained");
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.ld_addr       = {32'h24, 32'h10};
    bus.ld_addr_valid = 2'b01;
    bus.ld_data_ready = 2'b11;
    #2;
    total++; if (bus.ld_addr_ready !== 2'b01) begin bad++; $display("FAIL midrst_grant got=%b exp=01", bus.ld_addr_ready); end
    step();
    bus.ld_addr_valid = 2'b00;
    #1 rst = 1'b1;
    #1;
    total++; if (bus.idle !== 1'b1 || bus.ld_data_valid !== 2'b00) begin bad++; $display("FAIL midrst_async got=%b/%b exp=1/00", bus.idle, bus.ld_data_valid); end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #2;
      total++; if (bus.ld_data_valid !== 2'b00) begin bad++; $display("FAIL midrst_valid cycle=%0d got=%b exp=00", c, bus.ld_data_valid); end
      step();
    end
    bus.ld_addr_valid = 2'b11;
    #2;
    total++; if (bus.ld_addr_ready !== 2'b01) begin bad++; $display("FAIL midrst_ptr got=%b exp=01", bus.ld_addr_ready); end
    step();
    clear_inputs();
    $display("test_reset_midflight: in-flight load discarded");
  endtask

  task automatic test_priority();
    do_reset();
    bus.ld_addr       = {32'h0, 32'h10};
    bus.ld_addr_valid = 2'b01;
    bus.ld_data_ready = 2'b11;
    bus.st_addr       = 32'h8;
    bus.st_data       = 32'h77;
    bus.st_addr_valid = 1'b1;
    bus.st_data_valid = 1'b1;
    #2;
`ifdef MEM_ARB_STORE_FIRST_EN
    total++; if ({bus.st_ready, bus.ld_addr_ready} !== 3'b100) begin bad++; $display("FAIL prio_first got=%b exp=100", {bus.st_ready, bus.ld_addr_ready}); end
    step();
    bus.st_addr_valid = 1'b0;
    bus.st_data_valid = 1'b0;
    #2;
    total++; if ({bus.st_ready, bus.ld_addr_ready} !== 3'b001) begin bad++; $display("FAIL prio_second got=%b exp=001", {bus.st_ready, bus.ld_addr_ready}); end
`else
    total++; if ({bus.st_ready, bus.ld_addr_ready} !== 3'b001) begin bad++; $display("FAIL prio_first got=%b exp=001", {bus.st_ready, bus.ld_addr_ready}); end
    step();
    #2;
    total++; if ({bus.st_ready, bus.ld_addr_ready} !== 3'b100) begin bad++; $display("FAIL prio_second got=%b exp=100", {bus.st_ready, bus.ld_addr_ready}); end
`endif
    step();
    clear_inputs();
    $display("test_priority: load0 and store0 contending");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tbmem[i] = 32'h1111_0000 | i;
    tbmem[8'h10] = 32'hAB;
    tbmem[8'h40] = 32'hDEAD_0040;
    rdata_q = '0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_load();
`ifndef MEM_ARB_STORE_FIRST_EN
    test_round_robin();
`endif
    test_store_join();
    test_hold();
    test_reset_midflight();
    test_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
